// File: rtl/kyber_pkg.sv
// Shared parameters and types for the sequenced Baby-Kyber decryption controller.
package kyber_pkg;

  localparam int Q      = 17;
  localparam int N      = 4;
  localparam int K      = 2;
  localparam int CW     = 8;
  localparam int DEC_LO = 5;
  localparam int DEC_HI = 13;

  typedef logic [CW-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    FIN,
    DONE
  } state_t;

  // Counter width that stays at least one bit when the range collapses to 1.
  function automatic int cnt_width(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/kyber_modq_mac.sv
// Combinational shared mod-Q multiply-accumulate: res = (acc +/- a*b) mod Q.
module kyber_modq_mac
  import kyber_pkg::*;
#(
  parameter int Q  = kyber_pkg::Q,
  parameter int CW = kyber_pkg::CW
) (
  input  logic [CW-1:0] acc,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          neg,
  output logic [CW-1:0] res
);

  localparam logic [2*CW-1:0] QW = (2*CW)'(Q);

  logic [2*CW-1:0] prod;
  logic [2*CW-1:0] prod_mod;
  logic [2*CW-1:0] sum;

  // Subtraction is done as acc + (Q - p) so every intermediate stays unsigned.
  always_comb begin
    prod     = {{CW{1'b0}}, a} * {{CW{1'b0}}, b};
    prod_mod = prod % QW;
    sum      = {{CW{1'b0}}, acc} + (neg ? (QW - prod_mod) : prod_mod);
    if (sum >= QW) sum = sum - QW;
    res = CW'(sum);
  end

endmodule

// File: rtl/kyber_decrypt_ctrl.sv
// Sequenced Baby-Kyber decryption: w = v - sum_j u[j]*s[j] in Z_Q[X]/(X^N+1),
// one product per cycle through a shared MAC, then threshold-decode w to N bits.
module kyber_decrypt_ctrl
  import kyber_pkg::*;
#(
  parameter int Q      = kyber_pkg::Q,
  parameter int N      = kyber_pkg::N,
  parameter int K      = kyber_pkg::K,
  parameter int CW     = kyber_pkg::CW,
  parameter int DEC_LO = kyber_pkg::DEC_LO,
  parameter int DEC_HI = kyber_pkg::DEC_HI
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [K-1:0][N-1:0][CW-1:0]  u_in,
  input  logic [N-1:0][CW-1:0]         v_in,
  input  logic [K-1:0][N-1:0][CW-1:0]  sk_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N-1:0]                 m_out,
  output logic                         busy
);

  localparam int JW = cnt_width(K);
  localparam int IW = cnt_width(N);
  localparam logic [CW-1:0] QC = CW'(Q);
  localparam logic [CW:0]   QX = (CW+1)'(Q);
  localparam logic [CW:0]   LO = (CW+1)'(DEC_LO);
  localparam logic [CW:0]   HI = (CW+1)'(DEC_HI);
  localparam logic [IW:0]   NX = (IW+1)'(N);

  state_t state, state_nxt;

  logic [JW-1:0] j;
  logic [IW-1:0] i, k;
  logic [CW-1:0] u_r [K][N];
  logic [CW-1:0] s_r [K][N];
  logic [CW-1:0] v_r [N];
  logic [CW-1:0] acc [N];

  logic          accept;
  logic          last;
  logic [IW:0]   idx_sum;
  logic [IW-1:0] idx;
  logic          neg;
  logic [CW-1:0] mac_res;
  logic [CW:0]   w [N];
  logic [N-1:0]  m_nxt;

  function automatic logic [CW-1:0] mod_q(input logic [CW-1:0] x);
    return x % QC;
  endfunction

  // NOTE: every signal assigned in a combinational block gets a default at the
  // top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = MAC;
      MAC:     if (last)      state_nxt = FIN;
      FIN:                    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // X^N = -1: products landing at degree >= N fold back with a sign flip.
  always_comb begin
    last    = (j == JW'(K-1)) && (i == IW'(N-1)) && (k == IW'(N-1));
    idx_sum = {1'b0, i} + {1'b0, k};
    neg     = (idx_sum >= NX);
    idx     = IW'(neg ? (idx_sum - NX) : idx_sum);
  end

  kyber_modq_mac #(.Q(Q), .CW(CW)) u_mac (
    .acc (acc[idx]),
    .a   (u_r[j][i]),
    .b   (s_r[j][k]),
    .neg (neg),
    .res (mac_res)
  );

  always_comb begin
    m_nxt = '0;
    for (int n = 0; n < N; n++) begin
      w[n] = {1'b0, v_r[n]} + QX - {1'b0, acc[n]};
      if (w[n] >= QX) w[n] = w[n] - QX;
      m_nxt[n] = (w[n] >= LO) && (w[n] <= HI);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      j     <= '0;
      i     <= '0;
      k     <= '0;
      m_out <= '0;
      for (int n = 0; n < N; n++) acc[n] <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          j <= '0;
          i <= '0;
          k <= '0;
          for (int n = 0; n < N; n++) acc[n] <= '0;
        end
        MAC: begin
          acc[idx] <= mac_res;
          k <= k + 1'b1;
          if (k == IW'(N-1)) begin
            k <= '0;
            i <= i + 1'b1;
            if (i == IW'(N-1)) begin
              i <= '0;
              j <= j + 1'b1;
            end
          end
        end
        FIN:     m_out <= m_nxt;
        default: ;
      endcase
    end
  end

  // NOTE: operand arrays carry no reset; they are always written on accept
  // before any read, so a reset network on them would buy nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int jj = 0; jj < K; jj++) begin
        for (int ii = 0; ii < N; ii++) begin
          u_r[jj][ii] <= mod_q(u_in[jj][ii]);
          s_r[jj][ii] <= mod_q(sk_in[jj][ii]);
        end
      end
      for (int ii = 0; ii < N; ii++) v_r[ii] <= mod_q(v_in[ii]);
    end
  end

endmodule

// File: tb/tb_kyber_decrypt_ctrl.sv
// Directed and randomized checks of kyber_decrypt_ctrl against hand values and an integer model.
module tb_kyber_decrypt_ctrl;
  import kyber_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        in_valid = 1'b0;
  logic                        in_ready;
  logic [K-1:0][N-1:0][CW-1:0] u_in = '0;
  logic [N-1:0][CW-1:0]        v_in = '0;
  logic [K-1:0][N-1:0][CW-1:0] sk_in = '0;
  logic                        out_valid;
  logic                        out_ready = 1'b0;
  logic [N-1:0]                m_out;
  logic                        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int u [K][N];
  int s [K][N];
  int v [N];

  always #5 clk = ~clk;

  kyber_decrypt_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .u_in      (u_in),
    .v_in      (v_in),
    .sk_in     (sk_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .m_out     (m_out),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_ops();
    for (int jj = 0; jj < K; jj++)
      for (int ii = 0; ii < N; ii++) begin
        u[jj][ii] = 0;
        s[jj][ii] = 0;
      end
    for (int ii = 0; ii < N; ii++) v[ii] = 0;
  endtask

  task automatic load();
    for (int jj = 0; jj < K; jj++)
      for (int ii = 0; ii < N; ii++) begin
        u_in[jj][ii]  = CW'(u[jj][ii]);
        sk_in[jj][ii] = CW'(s[jj][ii]);
      end
    for (int ii = 0; ii < N; ii++) v_in[ii] = CW'(v[ii]);
  endtask

  // Full negacyclic product in plain integers, reduced only at the end.
  function automatic logic [N-1:0] golden();
    int acc [N];
    int p, w;
    logic [N-1:0] m;
    for (int n = 0; n < N; n++) acc[n] = 0;
    for (int jj = 0; jj < K; jj++)
      for (int ii = 0; ii < N; ii++)
        for (int kk = 0; kk < N; kk++) begin
          p = (u[jj][ii] % Q) * (s[jj][kk] % Q);
          if (ii + kk < N) acc[ii+kk] += p;
          else             acc[ii+kk-N] -= p;
        end
    for (int n = 0; n < N; n++) begin
      w = (((v[n] % Q) - acc[n]) % Q + Q) % Q;
      m[n] = (w >= DEC_LO) && (w <= DEC_HI);
    end
    return m;
  endfunction

  task automatic start_txn();
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_before_accept", in_ready, 1);
    load();
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [N-1:0] exp, input bit chk_lat);
    int cyc = 0;
    int busy_cnt = 0;
    while (!out_valid && cyc < 200) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_out_valid"}, out_valid, 1);
    if (chk_lat) begin
      check({tag, "_latency"}, cyc, 33);
      check({tag, "_busy_cycles"}, busy_cnt, 33);
    end
    check({tag, "_m_out"}, m_out, exp);
  endtask

  task automatic ack();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("ack_in_ready", in_ready, 1);
    check("ack_out_valid", out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] exp;
    bit stable;

    clear_ops();
    #12;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_m_out", m_out, 0);
    check("reset_busy", busy, 0);
    @(negedge clk) rst = 1'b0;

    // Zero key: w = v.
    clear_ops();
    u[0] = '{3, 7, 11, 16};
    u[1] = '{1, 2, 4, 8};
    v    = '{0, 9, 9, 0};
    start_txn();
    wait_out("zero_key", 4'b0110, 1'b1);
    ack();

    // u0 = X^3, s0 = X: product X^4 = -1 lands in acc[0] as 16, w[0] = 9.
    clear_ops();
    u[0][3] = 1;
    s[0][1] = 1;
    v[0]    = 8;
    start_txn();
    wait_out("wrap", 4'b0001, 1'b0);
    ack();

    clear_ops();
    v = '{4, 5, 13, 14};
    start_txn();
    wait_out("bound_a", 4'b0110, 1'b0);
    ack();

    clear_ops();
    v = '{16, 0, 17, 255};
    start_txn();
    wait_out("bound_b", 4'b0000, 1'b0);
    ack();

    // Backpressure: result held, new requests ignored.
    clear_ops();
    v = '{9, 9, 0, 0};
    start_txn();
    wait_out("bp", 4'b0011, 1'b0);
    stable = 1'b1;
    clear_ops();
    v = '{9, 9, 9, 9};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      load();
      in_valid = c[0];
      @(posedge clk);
      #1;
      if (m_out !== 4'b0011 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    in_valid = 1'b0;
    check("bp_stable", stable, 1);
    ack();
    check("bp_m_out_held", m_out, 4'b0011);
    @(posedge clk);
    #1 check("bp_no_capture", busy, 0);

    // Reset ten cycles into MAC.
    clear_ops();
    u[0][3] = 1;
    s[0][1] = 1;
    v[0]    = 8;
    start_txn();
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_m_out", m_out, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk) rst = 1'b0;
    start_txn();
    wait_out("after_rst", 4'b0001, 1'b1);
    ack();

    for (int t = 0; t < 500; t++) begin
      for (int jj = 0; jj < K; jj++)
        for (int ii = 0; ii < N; ii++) begin
          u[jj][ii] = $urandom_range(0, 16);
          s[jj][ii] = $urandom_range(0, 16);
        end
      for (int ii = 0; ii < N; ii++) v[ii] = $urandom_range(0, 16);
      exp = golden();
      start_txn();
      wait_out("rand", exp, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      ack();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
